imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time controller for the single-cycle core's instruction memory. It receives a program as a byte stream, assembles little-endian 32-bit words and writes them sequentially from word 0. It holds the core in reset until the load completes, then hands the memory read port to the core's PC. It sits between the board-level byte source (UART receiver or testbench) and the instruction memory plus core reset.

## Interface
Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; the maximum program length.
- AW, 32, address width of the memory ports (byte addresses).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session; ignored while a session is active.
- byte_valid  in  1  a stream byte is present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc  in  AW  core fetch address.
- mem_a  out  AW  read address to the instruction memory.
- mem_we  out  1  one-cycle write strobe.
- mem_wa  out  AW  write byte address, word aligned.
- mem_wd  out  32  write data.
- core_rst  out  1  active-low reset to the core; 0 holds the core in reset.
- busy  out  1  session in progress.
- done  out  1  last load completed successfully.
- err  out  1  last load rejected.

## Operation
- **States:**
  - IDLE: after reset, waits for start.
  - HDR0: count low byte.
  - HDR1: count high byte.
  - DATA: program bytes.
  - FLUSH: final write in flight.
  - DONE
  - ERR
- **Byte transfer:**
  - A byte transfers when byte_valid && byte_ready.
  - byte_ready = 1 only in HDR0, HDR1 and DATA.
- **Header:**
  - The header is a 16-bit word count N, little-endian.
  - N = 0: go to DONE directly from HDR1.
  - N > DEPTH: go to ERR.
  - Otherwise: go to DATA.
- **Data bytes:**
  - Bytes fill word bits [7:0], [15:8], [23:16], [31:24] in order; a 2-bit byte counter wraps.
  - On the 4th byte, the assembled word is registered into mem_wd, mem_wa = word_index*4, and mem_we = 1 in the next cycle.
  - Assembly of the next word continues in parallel, with no stall.
  - word_index increments after each write.
  - After the 4th byte of word N-1 is accepted: go to FLUSH, then DONE.
- **Outputs per state:**
  - core_rst = 1 only in DONE.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
  - busy = 1 in HDR0, HDR1, DATA and FLUSH.
  - mem_a = pc in DONE, otherwise 0.
- **start handling:**
  - start in IDLE, DONE or ERR begins a new session (go to HDR0). Leaving DONE drops core_rst to 0 in that same transition.
  - start in HDR0, HDR1, DATA or FLUSH is ignored.
- **No timeout.** A stalled stream holds the FSM in its current state indefinitely.

## Timing
- **Reset values:**
  - state IDLE
  - byte_ready 0, mem_we 0, mem_wa 0, mem_wd 0, mem_a 0
  - core_rst 0, busy 0, done 0, err 0
  - internal counters 0
- **Reset mid-session:** asserting rst returns to IDLE immediately and asynchronously. Words already written are not cleared.
- **Start latency:** start sampled high at edge k → state HDR0 and byte_ready = 1 from edge k+1.
- **Write latency:** 4th byte of a word accepted at edge t → mem_we = 1 for exactly the cycle between edges t and t+1, i.e. the write commits at edge t+1.
- **Throughput:** one byte per cycle sustained; at most one mem_we per 4 cycles.
- **Last word:** last byte accepted at edge t → FLUSH during the write cycle → DONE, core_rst = 1 and mem_a = pc from edge t+1 onward.
- **Width rules:**
  - mem_wa = {word_index, 2'b00}, truncated or zero-extended to AW.
  - word_index is clog2(DEPTH)+1 bits.
  - The N comparison is 16-bit unsigned.

## Structure
- Shared package: state encoding enum, header length constant (2 bytes) and byte-lane constants.
- One natural sub-module: `byte_word_packer`. It has the 2-bit lane counter, the 32-bit assembly register and a word_valid pulse output; the FSM owns counting, addressing and mem_we.

## Test plan
- Reset with rst = 0 mid-DATA → all outputs at reset values, state IDLE, core_rst = 0.
- start, header 02 00, bytes 03 A3 C4 FF 13 00 00 00 at one per cycle → mem_we at word 0 with mem_wd = FFC4A303, mem_wa = 0; then mem_wd = 00000013, mem_wa = 4; done = 1 and core_rst = 1 after the final write; mem_a follows pc.
- byte_valid toggling at random with the same stream → identical writes; mem_we never asserted outside the word boundaries.
- Header 00 00 → DONE directly after HDR1, no mem_we.
- Header 01 04 (N = 1025, DEPTH = 1024) → ERR, err = 1, core_rst = 0, byte_ready = 0; a following start restarts the load and then completes normally.
- start pulsed during DATA → ignored, session completes unchanged; start in DONE → core_rst falls the next cycle and a new load begins.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states,
// header size and byte-lane positions inside an assembled word.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam int HDR_BYTES = 2;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; o_word_vld pulses
// combinationally with the 4th byte so the caller can register the word that cycle.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat
);

    logic [1:0]  r_lane;
    logic [23:0] r_asm;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_lane <= LANE_B0;
            r_asm  <= '0;
        end else if (i_clr) begin
            r_lane <= LANE_B0;
            r_asm  <= '0;
        end else if (i_byte_vld) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
                LANE_B0: r_asm[7:0]   <= i_byte_dat;
                LANE_B1: r_asm[15:8]  <= i_byte_dat;
                LANE_B2: r_asm[23:16] <= i_byte_dat;
                LANE_B3: ;
                default: ;
            endcase
        end
    end

    // Top lane is never stored: it is forwarded straight into the output word.
    assign o_word_vld = i_byte_vld && (r_lane == LANE_B3);
    assign o_word_dat = {i_byte_dat, r_asm};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory from word 0,
// holding the core in reset until the last word is written.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    input  logic [AW-1:0] i_pc,
    output logic [AW-1:0] o_mem_a,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_wa,
    output logic [31:0]   o_mem_wd,
    output logic          o_core_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int IW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = 8 * HDR_BYTES;
    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

    state_t           r_state;
    logic [7:0]       r_cnt_lo;
    logic [CNT_W-1:0] r_count;
    logic [IW-1:0]    r_widx;

    logic             w_xfer;
    logic             w_start_ok;
    logic             w_pack_vld;
    logic             w_word_vld;
    logic [31:0]      w_word_dat;
    logic [CNT_W-1:0] w_hdr_n;
    logic             w_last;
    logic [AW-1:0]    w_wa;

    assign w_xfer     = i_byte_valid && o_byte_ready;
    assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERR));
    assign w_pack_vld = w_xfer && (r_state == ST_DATA);
    assign w_hdr_n    = {i_byte_data, r_cnt_lo};
    assign w_last     = ((32'(r_widx) + 32'd1) == 32'(r_count));
    assign w_wa       = AW'({r_widx, 2'b00});

    byte_word_packer u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_start_ok),
        .i_byte_vld (w_pack_vld),
        .i_byte_dat (i_byte_data),
        .o_word_vld (w_word_vld),
        .o_word_dat (w_word_dat)
    );

    // The core only sees its PC on the memory once the image is complete.
    assign o_mem_a = (r_state == ST_DONE) ? i_pc : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt_lo     <= '0;
            r_count      <= '0;
            r_widx       <= '0;
            o_byte_ready <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_wa     <= '0;
            o_mem_wd     <= '0;
            o_core_rst   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_state      <= ST_HDR0;
                        r_cnt_lo     <= '0;
                        r_count      <= '0;
                        r_widx       <= '0;
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
                        o_core_rst   <= 1'b0;
                    end
                end
                ST_HDR0: begin
                    if (w_xfer) begin
                        r_cnt_lo <= i_byte_data;
                        r_state  <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (w_xfer) begin
                        r_count <= w_hdr_n;
                        if (w_hdr_n == '0) begin
                            r_state      <= ST_DONE;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                            o_core_rst   <= 1'b1;
                        end else if (w_hdr_n > DEPTH_N) begin
                            r_state      <= ST_ERR;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_err        <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_vld) begin
                        o_mem_we <= 1'b1;
                        o_mem_wa <= w_wa;
                        o_mem_wd <= w_word_dat;
                        r_widx   <= r_widx + 1'b1;
                        if (w_last) begin
                            r_state      <= ST_FLUSH;
                            o_byte_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state    <= ST_DONE;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b1;
                    o_core_rst <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: cycle table for the reference program, directed
// corner cases and randomized sessions checked against a stream-level model.
module tb_imem_boot_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] pc;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .i_pc         (pc),
        .o_mem_a      (mem_a),
        .o_mem_we     (mem_we),
        .o_mem_wa     (mem_wa),
        .o_mem_wd     (mem_wd),
        .o_core_rst   (core_rst),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        er;
        logic        cr;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ma;
    } vec_t;

    vec_t tbl[12];

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    logic [31:0] ex_a_q[$];
    logic [31:0] ex_d_q[$];
    bit          ex_done;
    bit          ex_err;
    int          ex_lat;

    // Write log, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            wr_a_q.push_back(mem_wa);
            wr_d_q.push_back(mem_wd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic st, input logic vld, input logic [7:0] dat,
                                 input logic rdy, input logic bsy, input logic dn,
                                 input logic er, input logic cr, input logic we,
                                 input logic [31:0] wa, input logic [31:0] wd,
                                 input logic [31:0] ma);
        vec_t v;
        v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
        v.er = er; v.cr = cr; v.we = we; v.wa = wa; v.wd = wd; v.ma = ma;
        return v;
    endfunction

    // Expected outcome of the current stream: header count decides the result,
    // each group of four data bytes becomes one little-endian word at 4*index.
    task automatic build_model;
        int n;
        n = int'({stream[1], stream[0]});
        ex_a_q.delete();
        ex_d_q.delete();
        ex_done = 1'b0;
        ex_err  = 1'b0;
        ex_lat  = 0;
        if (n == 0) begin
            ex_done = 1'b1;
        end else if (n > DEPTH) begin
            ex_err = 1'b1;
        end else begin
            ex_done = 1'b1;
            ex_lat  = 1;
            for (int w = 0; w < n; w++) begin
                ex_a_q.push_back(32'(w * 4));
                ex_d_q.push_back({stream[4*w+5], stream[4*w+4], stream[4*w+3], stream[4*w+2]});
            end
        end
    endtask

    task automatic make_stream(input int n);
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
        end
    endtask

    task automatic send_stream(input int pct, input bit noise);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < stream.size() && cyc < 5000) begin
            byte_valid = ($urandom_range(99) < pct);
            byte_data  = byte_valid ? stream[idx] : 8'($urandom);
            start      = noise && ($urandom_range(7) == 0);
            acc        = byte_valid && byte_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        chk("stream_complete", idx, stream.size());
    endtask

    task automatic finish_session(input int pct, input bit noise);
        int w;
        logic [31:0] pcv;
        wr_a_q.delete();
        wr_d_q.delete();
        build_model();
        send_stream(pct, noise);
        w = 0;
        while (!(done || err) && w < 20) begin
            tick();
            w++;
        end
        chk("end_latency", w, ex_lat);
        chk("done", done, ex_done);
        chk("err", err, ex_err);
        chk("core_rst", core_rst, ex_done);
        chk("ready_end", byte_ready, 0);
        chk("busy_end", busy, 0);
        chk("write_count", wr_a_q.size(), ex_a_q.size());
        for (int i = 0; i < ex_a_q.size() && i < wr_a_q.size(); i++) begin
            chk("write_addr", wr_a_q[i], ex_a_q[i]);
            chk("write_data", wr_d_q[i], ex_d_q[i]);
        end
        pcv = $urandom | 32'h1;
        pc  = pcv;
        #1;
        chk("mem_a_end", mem_a, ex_done ? pcv : 32'h0);
    endtask

    task automatic run_session(input int pct, input bit noise);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", byte_ready, 1);
        finish_session(pct, noise);
    endtask

    initial begin
        int n;
        int pct;

        tbl[0]  = mkv(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[1]  = mkv(0, 1, 8'h02, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[2]  = mkv(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[3]  = mkv(0, 1, 8'h03, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[4]  = mkv(0, 1, 8'hA3, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[5]  = mkv(0, 1, 8'hC4, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[6]  = mkv(0, 1, 8'hFF, 1, 1, 0, 0, 0, 1, 32'h0, 32'hFFC4A303, 32'h0);
        tbl[7]  = mkv(0, 1, 8'h13, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[8]  = mkv(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[9]  = mkv(0, 1, 8'h00, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0,        32'h0);
        tbl[10] = mkv(0, 1, 8'h00, 0, 1, 0, 0, 0, 1, 32'h4, 32'h00000013, 32'h0);
        tbl[11] = mkv(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0,        32'hABC);

        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pc         = 32'hABC;
        #12;
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_core_rst", core_rst, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reference program, one byte per cycle, checked edge by edge.
        for (int i = 0; i < 12; i++) begin
            start      = tbl[i].st;
            byte_valid = tbl[i].vld;
            byte_data  = tbl[i].dat;
            tick();
            chk($sformatf("tbl%0d_ready", i), byte_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
            chk($sformatf("tbl%0d_core_rst", i), core_rst, tbl[i].cr);
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("tbl%0d_mem_a", i), mem_a, tbl[i].ma);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_wa", i), mem_wa, tbl[i].wa);
                chk($sformatf("tbl%0d_wd", i), mem_wd, tbl[i].wd);
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        // Start while DONE: core goes back into reset on the very next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_core_rst", core_rst, 0);
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_ready", byte_ready, 1);
        stream = '{8'h02, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h13, 8'h00, 8'h00, 8'h00};
        finish_session(40, 1'b0);

        // Same program with start pulses sprinkled through the session.
        stream = '{8'h02, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h13, 8'h00, 8'h00, 8'h00};
        run_session(60, 1'b1);

        stream = '{8'h00, 8'h00};
        run_session(100, 1'b0);

        stream = '{8'h01, 8'h04};
        run_session(100, 1'b0);
        make_stream(3);
        run_session(70, 1'b0);

        for (int s = 0; s < 16; s++) begin
            n   = ($urandom_range(7) == 0) ? int'($urandom_range(1025, 65535))
                                           : int'($urandom_range(0, 6));
            pct = (s % 3 == 0) ? 100 : ((s % 3 == 1) ? 60 : 25);
            make_stream(n);
            run_session(pct, 1'(s % 2));
        end

        // N = DEPTH is accepted; then an asynchronous reset lands mid-DATA.
        stream = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start = 1'b1;
        tick();
        start = 1'b0;
        send_stream(100, 1'b0);
        chk("maxn_busy", busy, 1);
        chk("maxn_err", err, 0);
        chk("maxn_ready", byte_ready, 1);
        chk("maxn_wd", mem_wd, 32'h44332211);
        pc = 32'h100;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ready", byte_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_core_rst", core_rst, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_wa", mem_wa, 0);
        chk("arst_wd", mem_wd, 0);
        chk("arst_mem_a", mem_a, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_ready", byte_ready, 0);
        make_stream(2);
        run_session(100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
